// File: rtl/axi_4_lite_master.sv
// AXI4-lite initiator: turns single core load/store/fetch requests into AR/R or AW/W/B transactions.
// Define AXI_MASTER_TIMEOUT_EN to enable the TIMEOUT_CYCLES watchdog.
module axi_4_lite_master #(
   parameter int         AXI_DATA_WIDTH = 64,
   parameter int         AXI_ADDR_WIDTH = 32,
   parameter logic [2:0] AXI_PROT       = 3'b000,
   parameter int         TIMEOUT_CYCLES = 1024
) (
   input  logic                        AXI_ACLK,
   input  logic                        AXI_ARESETN,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_wen,
   input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
   input  logic [AXI_DATA_WIDTH-1:0]   req_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0] req_wstrb,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
   output logic                        rsp_err,
   output logic [AXI_ADDR_WIDTH-1:0]   AXI_AWADDR,
   output logic [2:0]                  AXI_AWPROT,
   output logic                        AXI_AWVALID,
   input  logic                        AXI_AWREADY,
   output logic [AXI_DATA_WIDTH-1:0]   AXI_WDATA,
   output logic [AXI_DATA_WIDTH/8-1:0] AXI_WSTRB,
   output logic                        AXI_WVALID,
   input  logic                        AXI_WREADY,
   input  logic [1:0]                  AXI_BRESP,
   input  logic                        AXI_BVALID,
   output logic                        AXI_BREADY,
   output logic [AXI_ADDR_WIDTH-1:0]   AXI_ARADDR,
   output logic [2:0]                  AXI_ARPROT,
   output logic                        AXI_ARVALID,
   input  logic                        AXI_ARREADY,
   input  logic [AXI_DATA_WIDTH-1:0]   AXI_RDATA,
   input  logic [1:0]                  AXI_RRESP,
   input  logic                        AXI_RVALID,
   output logic                        AXI_RREADY
);

   localparam int STRB_W = AXI_DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      RD_ADDR      = 3'd1,
      RD_DATA      = 3'd2,
      WR_ADDR_DATA = 3'd3,
      WR_RESP      = 3'd4,
      RSP          = 3'd5
   } state_t;

   state_t                      r_state,     w_state_nxt;
   logic                        r_req_ready, w_req_ready_nxt;
   logic                        r_rsp_valid, w_rsp_valid_nxt;
   logic [AXI_DATA_WIDTH-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
   logic                        r_rsp_err,   w_rsp_err_nxt;
   logic [AXI_ADDR_WIDTH-1:0]   r_awaddr,    w_awaddr_nxt;
   logic                        r_awvalid,   w_awvalid_nxt;
   logic [AXI_DATA_WIDTH-1:0]   r_wdata,     w_wdata_nxt;
   logic [STRB_W-1:0]           r_wstrb,     w_wstrb_nxt;
   logic                        r_wvalid,    w_wvalid_nxt;
   logic                        r_bready,    w_bready_nxt;
   logic [AXI_ADDR_WIDTH-1:0]   r_araddr,    w_araddr_nxt;
   logic                        r_arvalid,   w_arvalid_nxt;
   logic                        r_rready,    w_rready_nxt;
   logic                        r_aw_done,   w_aw_done_nxt;
   logic                        r_w_done,    w_w_done_nxt;

`ifdef AXI_MASTER_TIMEOUT_EN
   localparam int                TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0]              r_to_cnt, w_to_cnt_nxt;
`endif

   // State and every output register; reset drops all handshakes immediately
   always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
      if (!AXI_ARESETN) begin
         r_state     <= IDLE;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_awaddr    <= '0;
         r_awvalid   <= 1'b0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_araddr    <= '0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
         r_to_cnt    <= '0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_req_ready <= w_req_ready_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
         r_awaddr    <= w_awaddr_nxt;
         r_awvalid   <= w_awvalid_nxt;
         r_wdata     <= w_wdata_nxt;
         r_wstrb     <= w_wstrb_nxt;
         r_wvalid    <= w_wvalid_nxt;
         r_bready    <= w_bready_nxt;
         r_araddr    <= w_araddr_nxt;
         r_arvalid   <= w_arvalid_nxt;
         r_rready    <= w_rready_nxt;
         r_aw_done   <= w_aw_done_nxt;
         r_w_done    <= w_w_done_nxt;
`ifdef AXI_MASTER_TIMEOUT_EN
         r_to_cnt    <= w_to_cnt_nxt;
`endif
      end
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt     = r_state;
      w_req_ready_nxt = r_req_ready;
      w_rsp_valid_nxt = r_rsp_valid;
      w_rsp_rdata_nxt = r_rsp_rdata;
      w_rsp_err_nxt   = r_rsp_err;
      w_awaddr_nxt    = r_awaddr;
      w_awvalid_nxt   = r_awvalid;
      w_wdata_nxt     = r_wdata;
      w_wstrb_nxt     = r_wstrb;
      w_wvalid_nxt    = r_wvalid;
      w_bready_nxt    = r_bready;
      w_araddr_nxt    = r_araddr;
      w_arvalid_nxt   = r_arvalid;
      w_rready_nxt    = r_rready;
      w_aw_done_nxt   = r_aw_done;
      w_w_done_nxt    = r_w_done;
`ifdef AXI_MASTER_TIMEOUT_EN
      w_to_cnt_nxt    = r_to_cnt;
`endif

      case (r_state)
         IDLE: begin
            if (req_valid && r_req_ready) begin
               w_req_ready_nxt = 1'b0;
               if (!req_wen) begin
                  w_araddr_nxt  = req_addr;
                  w_arvalid_nxt = 1'b1;
                  w_state_nxt   = RD_ADDR;
               end else begin
                  w_awaddr_nxt  = req_addr;
                  w_wdata_nxt   = req_wdata;
                  w_wstrb_nxt   = req_wstrb;
                  w_awvalid_nxt = 1'b1;
                  w_wvalid_nxt  = 1'b1;
                  w_aw_done_nxt = 1'b0;
                  w_w_done_nxt  = 1'b0;
                  w_state_nxt   = WR_ADDR_DATA;
               end
            end else begin
               w_state_nxt = IDLE;
            end
         end
         RD_ADDR: begin
            if (AXI_ARREADY) begin
               w_arvalid_nxt = 1'b0;
               w_rready_nxt  = 1'b1;
               w_state_nxt   = RD_DATA;
            end else begin
               w_state_nxt = RD_ADDR;
            end
         end
         RD_DATA: begin
            if (AXI_RVALID && r_rready) begin
               w_rsp_rdata_nxt = AXI_RDATA;
               w_rsp_err_nxt   = (AXI_RRESP != 2'b00);
               w_rready_nxt    = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_state_nxt     = RSP;
            end else begin
               w_state_nxt = RD_DATA;
            end
         end
         WR_ADDR_DATA: begin
            // AW and W retire independently; move on once both have completed
            w_aw_done_nxt = r_aw_done | (r_awvalid & AXI_AWREADY);
            w_w_done_nxt  = r_w_done  | (r_wvalid  & AXI_WREADY);
            w_awvalid_nxt = r_awvalid & ~AXI_AWREADY;
            w_wvalid_nxt  = r_wvalid  & ~AXI_WREADY;
            if (w_aw_done_nxt && w_w_done_nxt) begin
               w_aw_done_nxt = 1'b0;
               w_w_done_nxt  = 1'b0;
               w_bready_nxt  = 1'b1;
               w_state_nxt   = WR_RESP;
            end else begin
               w_state_nxt = WR_ADDR_DATA;
            end
         end
         WR_RESP: begin
            if (AXI_BVALID && r_bready) begin
               w_rsp_err_nxt   = (AXI_BRESP != 2'b00);
               w_rsp_rdata_nxt = '0;
               w_bready_nxt    = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_state_nxt     = RSP;
            end else begin
               w_state_nxt = WR_RESP;
            end
         end
         RSP: begin
            if (rsp_ready) begin
               w_rsp_valid_nxt = 1'b0;
               w_req_ready_nxt = 1'b1;
               w_state_nxt     = IDLE;
            end else begin
               w_state_nxt = RSP;
            end
         end
         default: begin
            w_state_nxt     = IDLE;
            w_req_ready_nxt = 1'b1;
            w_rsp_valid_nxt = 1'b0;
            w_awvalid_nxt   = 1'b0;
            w_wvalid_nxt    = 1'b0;
            w_bready_nxt    = 1'b0;
            w_arvalid_nxt   = 1'b0;
            w_rready_nxt    = 1'b0;
            w_aw_done_nxt   = 1'b0;
            w_w_done_nxt    = 1'b0;
         end
      endcase

`ifdef AXI_MASTER_TIMEOUT_EN
      // Watchdog overrides any pending handshake and forces an error response
      if (r_state == IDLE) begin
         if (req_valid && r_req_ready) begin
            w_to_cnt_nxt = '0;
         end else begin
            w_to_cnt_nxt = r_to_cnt;
         end
      end else if (r_state == RD_ADDR || r_state == RD_DATA ||
                   r_state == WR_ADDR_DATA || r_state == WR_RESP) begin
         if (r_to_cnt == TO_LAST) begin
            w_arvalid_nxt   = 1'b0;
            w_rready_nxt    = 1'b0;
            w_awvalid_nxt   = 1'b0;
            w_wvalid_nxt    = 1'b0;
            w_bready_nxt    = 1'b0;
            w_aw_done_nxt   = 1'b0;
            w_w_done_nxt    = 1'b0;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_rdata_nxt = '0;
            w_rsp_valid_nxt = 1'b1;
            w_state_nxt     = RSP;
         end else begin
            w_to_cnt_nxt = r_to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
         end
      end else begin
         w_to_cnt_nxt = r_to_cnt;
      end
`endif
   end

   assign req_ready   = r_req_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_rsp_err;
   assign AXI_AWADDR  = r_awaddr;
   assign AXI_AWPROT  = AXI_PROT;
   assign AXI_AWVALID = r_awvalid;
   assign AXI_WDATA   = r_wdata;
   assign AXI_WSTRB   = r_wstrb;
   assign AXI_WVALID  = r_wvalid;
   assign AXI_BREADY  = r_bready;
   assign AXI_ARADDR  = r_araddr;
   assign AXI_ARPROT  = AXI_PROT;
   assign AXI_ARVALID = r_arvalid;
   assign AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axi_4_lite_master.sv
// Self-checking bench for axi_4_lite_master: directed cases plus randomized transactions
// against a transaction-level expectation model (latency, payload, response, handshake timing).
module tb_axi_4_lite_master;

   logic        clk;
   logic        rst_n;
   logic        req_valid, req_ready, req_wen;
   logic [31:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wstrb;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [63:0] rsp_rdata;
   logic [31:0] awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [63:0] wdata, rdata;
   logic [7:0]  wstrb;
   logic [1:0]  bresp, rresp;

   int n_checks = 0;
   int n_fail   = 0;

   axi_4_lite_master #(
      .AXI_DATA_WIDTH(64),
      .AXI_ADDR_WIDTH(32),
      .AXI_PROT(3'b000),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .AXI_ACLK(clk),       .AXI_ARESETN(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_addr(req_addr),   .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .AXI_AWADDR(awaddr),   .AXI_AWPROT(awprot),   .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
      .AXI_WDATA(wdata),     .AXI_WSTRB(wstrb),     .AXI_WVALID(wvalid),   .AXI_WREADY(wready),
      .AXI_BRESP(bresp),     .AXI_BVALID(bvalid),   .AXI_BREADY(bready),
      .AXI_ARADDR(araddr),   .AXI_ARPROT(arprot),   .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
      .AXI_RDATA(rdata),     .AXI_RRESP(rresp),     .AXI_RVALID(rvalid),   .AXI_RREADY(rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // One full transaction; the slave side answers after the given delays.
   // Expected response and latency come from the transaction rules, not the RTL.
   task automatic run_txn(input bit wen, input logic [31:0] addr, input logic [63:0] wd,
                          input logic [7:0] ws, input logic [63:0] rd, input logic [1:0] resp,
                          input int a_dly, input int w_dly, input int d_dly, input int rsp_dly);
      int          lat;
      int          n;
      logic [63:0] exp_data;
      logic        exp_err;
      exp_err  = (resp != 2'b00);
      exp_data = wen ? 64'd0 : rd;
      check_eq("req_ready_idle", req_ready, 64'd1);
      req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wd; req_wstrb = ws;
      @(posedge clk);
      lat = 0;
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = ~addr; req_wdata = ~wd; req_wstrb = ~ws;
      check_eq("req_ready_busy", req_ready, 64'd0);
      check_eq("awprot", {61'd0, awprot}, 64'd0);
      check_eq("arprot", {61'd0, arprot}, 64'd0);
      if (!wen) begin
         for (int c = 0; c <= a_dly; c++) begin
            check_eq("arvalid_held", arvalid, 64'd1);
            check_eq("araddr", {32'd0, araddr}, {32'd0, addr});
            check_eq("awvalid_quiet", awvalid, 64'd0);
            arready = (c == a_dly);
            @(posedge clk); lat++; @(negedge clk);
         end
         arready = 1'b0;
         check_eq("arvalid_drop", arvalid, 64'd0);
         for (int c = 0; c <= d_dly; c++) begin
            check_eq("rready_high", rready, 64'd1);
            check_eq("rsp_valid_early", rsp_valid, 64'd0);
            rvalid = (c == d_dly);
            rdata  = (c == d_dly) ? rd : {$urandom, $urandom};
            rresp  = resp;
            @(posedge clk); lat++; @(negedge clk);
         end
         rvalid = 1'b0;
         check_eq("rready_drop", rready, 64'd0);
         check_eq("latency_rd", lat + 1, 3 + a_dly + d_dly);
      end else begin
         n = (a_dly > w_dly) ? a_dly : w_dly;
         for (int c = 0; c <= n; c++) begin
            check_eq("awvalid", awvalid, (c <= a_dly) ? 64'd1 : 64'd0);
            check_eq("wvalid", wvalid, (c <= w_dly) ? 64'd1 : 64'd0);
            check_eq("bready_early", bready, 64'd0);
            if (c <= a_dly) check_eq("awaddr", {32'd0, awaddr}, {32'd0, addr});
            if (c <= w_dly) begin
               check_eq("wdata", wdata, wd);
               check_eq("wstrb", {56'd0, wstrb}, {56'd0, ws});
            end
            awready = (c == a_dly);
            wready  = (c == w_dly);
            @(posedge clk); lat++; @(negedge clk);
         end
         awready = 1'b0; wready = 1'b0;
         check_eq("awvalid_drop", awvalid, 64'd0);
         check_eq("wvalid_drop", wvalid, 64'd0);
         for (int c = 0; c <= d_dly; c++) begin
            check_eq("bready_high", bready, 64'd1);
            check_eq("rsp_valid_early", rsp_valid, 64'd0);
            bvalid = (c == d_dly);
            bresp  = resp;
            @(posedge clk); lat++; @(negedge clk);
         end
         bvalid = 1'b0;
         check_eq("bready_drop", bready, 64'd0);
         check_eq("latency_wr", lat + 1, 3 + n + d_dly);
      end
      for (int c = 0; c <= rsp_dly; c++) begin
         check_eq("rsp_valid", rsp_valid, 64'd1);
         check_eq("rsp_rdata", rsp_rdata, exp_data);
         check_eq("rsp_err", rsp_err, exp_err);
         check_eq("req_ready_rsp", req_ready, 64'd0);
         rsp_ready = (c == rsp_dly);
         @(posedge clk); @(negedge clk);
      end
      rsp_ready = 1'b0;
      check_eq("rsp_valid_drop", rsp_valid, 64'd0);
      check_eq("req_ready_back", req_ready, 64'd1);
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      rsp_ready = 1'b0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check_eq("rst_req_ready", req_ready, 64'd1);
      check_eq("rst_rsp_valid", rsp_valid, 64'd0);
      check_eq("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 64'd0);
      check_eq("rst_awaddr", {32'd0, awaddr}, 64'd0);
      check_eq("rst_araddr", {32'd0, araddr}, 64'd0);
      check_eq("rst_wdata", wdata, 64'd0);
      check_eq("rst_wstrb", {56'd0, wstrb}, 64'd0);
      check_eq("rst_rdata", rsp_rdata, 64'd0);
      check_eq("rst_err", rsp_err, 64'd0);

      // Directed cases
      run_txn(1'b0, 32'h8000_0000, 64'd0, 8'h00, 64'h0000_0000_0010_0093, 2'b00, 0, 0, 0, 0);
      run_txn(1'b0, 32'h8000_0004, 64'd0, 8'h00, 64'hDEAD_BEEF_0BAD_F00D, 2'b00, 3, 0, 0, 2);
      run_txn(1'b1, 32'h8000_0010, 64'h1122_3344_5566_7788, 8'h0F, 64'd0, 2'b00, 0, 2, 0, 0);
      run_txn(1'b1, 32'h8000_0020, 64'hA5A5_A5A5_5A5A_5A5A, 8'hFF, 64'd0, 2'b10, 1, 0, 1, 1);
      run_txn(1'b0, 32'h8000_0030, 64'd0, 8'h00, 64'h0123_4567_89AB_CDEF, 2'b11, 0, 0, 2, 0);
      run_txn(1'b1, 32'h0000_1000, 64'h0F0F_0F0F_0F0F_0F0F, 8'h3C, 64'd0, 2'b00, 2, 2, 0, 0);

      // Randomized transactions
      for (int i = 0; i < 40; i++) begin
         run_txn(1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom}, 8'($urandom),
                 {$urandom, $urandom}, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2));
      end

      // Stray slave activity while idle must be ignored
      rvalid = 1'b1; bvalid = 1'b1; arready = 1'b1; awready = 1'b1; wready = 1'b1;
      rdata = 64'hFFFF_FFFF_FFFF_FFFF; rresp = 2'b11; bresp = 2'b11;
      repeat (3) @(negedge clk);
      check_eq("stray_rsp_valid", rsp_valid, 64'd0);
      check_eq("stray_req_ready", req_ready, 64'd1);
      check_eq("stray_readys", {bready, rready}, 64'd0);
      rvalid = 1'b0; bvalid = 1'b0; arready = 1'b0; awready = 1'b0; wready = 1'b0;

      // Reset while in RD_DATA
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0040;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0; arready = 1'b1;
      @(posedge clk); @(negedge clk);
      arready = 1'b0;
      check_eq("mid_rready", rready, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("async_rready", rready, 64'd0);
      check_eq("async_req_ready", req_ready, 64'd1);
      check_eq("async_arvalid", arvalid, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rvalid = 1'b1; rdata = 64'h5555_5555_5555_5555;
      n = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (rsp_valid) n++;
      end
      rvalid = 1'b0;
      check_eq("no_rsp_after_rst", n, 64'd0);
      check_eq("idle_after_rst", req_ready, 64'd1);
      run_txn(1'b0, 32'h8000_0050, 64'd0, 8'h00, 64'h0000_0000_CAFE_0001, 2'b00, 1, 0, 1, 0);

`ifdef AXI_MASTER_TIMEOUT_EN
      // Slave never answers AR: watchdog forces an error response after 16 cycles
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h9000_0000;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 40) begin
         @(posedge clk); @(negedge clk);
         n++;
      end
      check_eq("timeout_cycles", n, 64'd16);
      check_eq("timeout_arvalid", arvalid, 64'd0);
      check_eq("timeout_err", rsp_err, 64'd1);
      check_eq("timeout_rdata", rsp_rdata, 64'd0);
      rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      rsp_ready = 1'b0;
      check_eq("timeout_req_ready", req_ready, 64'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
